// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: oversampled SPI frame deserialiser feeding three per-channel FIFO write ports,
// with frame completion / framing error reporting.
module spi_frame_receiver #(
  parameter int          FRAME_WORDS = 2165,
  parameter int          CH_WORDS    = 721,
  parameter logic [15:0] HEADER      = 16'h7A63,
  parameter logic [15:0] TRAILER     = 16'h7A68
) (
  input  logic        Clk200M,
  input  logic        Rst_n,
  input  logic        Cs_n,
  input  logic        Clk_in,
  input  logic        MOSI,
  output logic [15:0] wrdata,
  output logic        wrreq0,
  output logic        wrreq1,
  output logic        wrreq2,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);
  typedef enum logic [2:0] {ARM, IDLE, HDR, PAY, TRL, DONE, DROP} state_e;
  localparam logic [11:0] CH0_END = 12'(CH_WORDS);
  localparam logic [11:0] CH1_END = 12'(2 * CH_WORDS);
  localparam logic [11:0] PAY_END = 12'(FRAME_WORDS - 2);
  state_e      state_q, state_d;
  logic [1:0]  cs_q, cs_d, mosi_q, mosi_d;
  logic [2:0]  sclk_q, sclk_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] word_cnt_q, word_cnt_d;
  logic [15:0] shift_q, shift_d, wrdata_q, wrdata_d;
  logic [2:0]  wrreq_q, wrreq_d;
  logic        frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        cs_s, sclk_rise, capture, word_done, wr_en, hdr_bad, trl_done, short_frame;
  logic [15:0] word;
  assign cs_s        = cs_q[1];
  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign capture     = state_q inside {HDR, PAY, TRL};
  assign word_done   = capture & sclk_rise & (bit_cnt_q == 4'd15);
  assign word        = {shift_q[14:0], mosi_q[1]};
  assign wr_en       = word_done & (state_q == PAY);
  assign hdr_bad     = word_done & (state_q == HDR) & (word != HEADER);
  assign trl_done    = word_done & (state_q == TRL);
  // A completing word wins over a same-cycle chip-select rise.
  assign short_frame = capture & ~word_done & cs_s;
  always_ff @(posedge Clk200M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ARM;
      cs_q          <= '0;
      sclk_q        <= '1;
      mosi_q        <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      shift_q       <= '0;
      wrdata_q      <= '0;
      wrreq_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      cs_q          <= cs_d;
      sclk_q        <= sclk_d;
      mosi_q        <= mosi_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      shift_q       <= shift_d;
      wrdata_q      <= wrdata_d;
      wrreq_q       <= wrreq_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
    end
  end
  // Chip select resets to "asserted" so ARM only leaves once the line is really seen high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cs_s ? IDLE : HDR;
      HDR:     state_d = word_done ? ((word == HEADER) ? PAY : DROP) : cs_s ? IDLE : HDR;
      PAY:     state_d = word_done ? ((word_cnt_q == PAY_END) ? TRL : PAY) : cs_s ? IDLE : PAY;
      TRL:     state_d = word_done ? DONE : cs_s ? IDLE : TRL;
      default: state_d = cs_s ? IDLE : state_q;
    endcase
  end
  always_comb begin
    cs_d          = {cs_q[0], Cs_n};
    sclk_d        = {sclk_q[1:0], Clk_in};
    mosi_d        = {mosi_q[0], MOSI};
    bit_cnt_d     = (state_q == IDLE) ? 4'd0 : (capture & sclk_rise) ? bit_cnt_q + 4'd1 : bit_cnt_q;
    word_cnt_d    = (state_q == IDLE) ? 12'd0 : word_done ? word_cnt_q + 12'd1 : word_cnt_q;
    shift_d       = (capture & sclk_rise) ? word : shift_q;
    wrreq_d       = !wr_en ? 3'b000 : (word_cnt_q <= CH0_END) ? 3'b001 :
                    (word_cnt_q <= CH1_END) ? 3'b010 : 3'b100;
    wrdata_d      = wr_en ? word : wrdata_q;
    frame_valid_d = trl_done & (word == TRAILER);
    frame_err_d   = hdr_bad | (trl_done & (word != TRAILER)) | short_frame;
    err_code_d    = hdr_bad ? 2'd1 : short_frame ? 2'd2 :
                    trl_done ? ((word == TRAILER) ? 2'd0 : 2'd3) : err_code_q;
  end
  assign wrdata      = wrdata_q;
  assign wrreq0      = wrreq_q[0];
  assign wrreq1      = wrreq_q[1];
  assign wrreq2      = wrreq_q[2];
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != ARM) && (state_q != IDLE);
endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver: randomized frames on a shortened frame geometry, checked against a
// word-level reference model of the write/valid/error outcome of each frame.
module tb_spi_frame_receiver;
  localparam int CH = 4;
  localparam int FW = 3 * CH + 2;
  localparam logic [15:0] HDR_W = 16'h7A63;
  localparam logic [15:0] TRL_W = 16'h7A68;
  logic Clk200M = 1'b0, Rst_n = 1'b0, Cs_n = 1'b1, Clk_in = 1'b1, MOSI = 1'b0;
  logic [15:0] wrdata;
  logic wrreq0, wrreq1, wrreq2, frame_valid, frame_err, busy;
  logic [1:0] err_code;
  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] fw [FW];
  int rise_cyc [FW];
  int exp_wr[$], obs_wr[$];
  int exp_fv, exp_fe, obs_fv, obs_fe, multi, first_wr_cyc, fv_cyc, fe_cyc;
  logic [1:0] exp_code, obs_code;
  logic busy_seen;
  logic [23:0] rst_snap;

  spi_frame_receiver #(.FRAME_WORDS(FW), .CH_WORDS(CH)) dut (
    .Clk200M(Clk200M), .Rst_n(Rst_n), .Cs_n(Cs_n), .Clk_in(Clk_in), .MOSI(MOSI),
    .wrdata(wrdata), .wrreq0(wrreq0), .wrreq1(wrreq1), .wrreq2(wrreq2),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 Clk200M = ~Clk200M;
  always @(posedge Clk200M) cyc <= cyc + 1;

  always @(negedge Clk200M) begin
    if (Rst_n) begin
      if (int'(wrreq0) + int'(wrreq1) + int'(wrreq2) > 1) multi++;
      if (wrreq0 | wrreq1 | wrreq2) begin
        obs_wr.push_back((wrreq1 ? 1 : wrreq2 ? 2 : 0) * 65536 + int'(wrdata));
        if (obs_wr.size() == 1) first_wr_cyc = cyc;
      end
      if (frame_valid) begin obs_fv++; fv_cyc = cyc; obs_code = err_code; end
      if (frame_err) begin obs_fe++; fe_cyc = cyc; obs_code = err_code; end
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic clear_all();
    exp_wr.delete(); obs_wr.delete();
    exp_fv = 0; exp_fe = 0; obs_fv = 0; obs_fe = 0; multi = 0;
    exp_code = 2'd0; obs_code = 2'd0; busy_seen = 1'b0;
    first_wr_cyc = -100; fv_cyc = -100; fe_cyc = -100;
  endtask

  task automatic build(input logic [15:0] hdr, input logic [15:0] trl, input bit idx);
    fw[0] = hdr;
    for (int w = 1; w < FW - 1; w++) fw[w] = idx ? 16'(w) : 16'($urandom);
    fw[FW-1] = trl;
  endtask

  // Outcome of a frame cut off after nbits serial bits, from the framing rules alone.
  task automatic model(input int nbits);
    int done = nbits / 16;
    if (done == 0) begin exp_fe++; exp_code = 2'd2; end
    else if (fw[0] !== HDR_W) begin exp_fe++; exp_code = 2'd1; end
    else begin
      for (int w = 1; w < done && w <= FW - 2; w++) exp_wr.push_back((w - 1) / CH * 65536 + int'(fw[w]));
      if (done < FW) begin exp_fe++; exp_code = 2'd2; end
      else if (fw[FW-1] === TRL_W) begin exp_fv++; exp_code = 2'd0; end
      else begin exp_fe++; exp_code = 2'd3; end
    end
  endtask

  task automatic drive(input int half, input int nbits, input int gap, input bit race, input int rst_bit);
    @(negedge Clk200M);
    Cs_n = 1'b0;
    repeat (half) @(negedge Clk200M);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_bit) begin
        Rst_n = 1'b0;
        #1 rst_snap = {wrdata, wrreq0, wrreq1, wrreq2, frame_valid, frame_err, err_code, busy};
        repeat (2) @(negedge Clk200M);
        Rst_n = 1'b1;
        obs_wr.delete(); obs_fv = 0; obs_fe = 0;
      end
      Clk_in = 1'b0;
      MOSI = fw[b / 16][15 - b % 16];
      repeat (half) @(negedge Clk200M);
      Clk_in = 1'b1;
      if (b % 16 == 15) rise_cyc[b / 16] = cyc;
      if (race && b == nbits - 1) Cs_n = 1'b1;
      else repeat (half) @(negedge Clk200M);
    end
    Cs_n = 1'b1;
    repeat (gap) @(negedge Clk200M);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk200M);
    checks++; if ({wrreq0, wrreq1, wrreq2} !== 3'b000) begin failures++; $display("FAIL reset_wrreq got %b want 000", {wrreq0, wrreq1, wrreq2}); end
    checks++; if (wrdata !== 16'h0) begin failures++; $display("FAIL reset_wrdata got %h want 0000", wrdata); end
    checks++; if ({frame_valid, frame_err} !== 2'b00) begin failures++; $display("FAIL reset_pulses got %b want 00", {frame_valid, frame_err}); end
    checks++; if (err_code !== 2'd0) begin failures++; $display("FAIL reset_err_code got %0d want 0", err_code); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    Rst_n = 1'b1;
    repeat (6) @(negedge Clk200M);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    bit bad;
    clear_all(); build(HDR_W, TRL_W, 1'b1); drive(5, FW * 16, 10, 1'b0, -1); model(FW * 16);
    bad = obs_wr.size() != exp_wr.size();
    foreach (exp_wr[i]) if (!bad && obs_wr[i] !== exp_wr[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL nominal_writes got %0d writes want %0d (or data/channel differs)", obs_wr.size(), exp_wr.size()); end
    checks++; if (obs_fv !== exp_fv) begin failures++; $display("FAIL nominal_valid got %0d want %0d", obs_fv, exp_fv); end
    checks++; if (obs_fe !== exp_fe) begin failures++; $display("FAIL nominal_err got %0d want %0d", obs_fe, exp_fe); end
    checks++; if (err_code !== 2'd0) begin failures++; $display("FAIL nominal_err_code got %0d want 0", err_code); end
    checks++; if (first_wr_cyc - rise_cyc[1] < 3 || first_wr_cyc - rise_cyc[1] > 5) begin failures++; $display("FAIL wr_latency got %0d want 3..5", first_wr_cyc - rise_cyc[1]); end
    checks++; if (fv_cyc - rise_cyc[FW-1] < 3 || fv_cyc - rise_cyc[FW-1] > 5) begin failures++; $display("FAIL valid_latency got %0d want 3..5", fv_cyc - rise_cyc[FW-1]); end
    checks++; if (multi != 0) begin failures++; $display("FAIL nominal_onehot got %0d multi-strobe cycles want 0", multi); end
  endtask

  task automatic test_bad_header();
    bit bad;
    clear_all(); build(16'h7A64, TRL_W, 1'b0); drive($urandom_range(4, 6), FW * 16, 10, 1'b0, -1); model(FW * 16);
    checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL badhdr_writes got %0d want 0", obs_wr.size()); end
    checks++; if (obs_fe !== 1 || obs_fv !== 0) begin failures++; $display("FAIL badhdr_pulses got err=%0d valid=%0d want err=1 valid=0", obs_fe, obs_fv); end
    checks++; if (obs_code !== exp_code) begin failures++; $display("FAIL badhdr_code got %0d want %0d", obs_code, exp_code); end
    checks++; if (fe_cyc - rise_cyc[0] < 3 || fe_cyc - rise_cyc[0] > 5) begin failures++; $display("FAIL badhdr_latency got %0d want 3..5", fe_cyc - rise_cyc[0]); end
    clear_all(); build(HDR_W, TRL_W, 1'b0); drive($urandom_range(4, 6), FW * 16, 10, 1'b0, -1); model(FW * 16);
    bad = obs_wr.size() != exp_wr.size();
    foreach (exp_wr[i]) if (!bad && obs_wr[i] !== exp_wr[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL after_badhdr_writes got %0d want %0d (or data differs)", obs_wr.size(), exp_wr.size()); end
    checks++; if (obs_fv !== 1 || obs_fe !== 0) begin failures++; $display("FAIL after_badhdr_pulses got valid=%0d err=%0d want 1/0", obs_fv, obs_fe); end
  endtask

  task automatic test_short_frame();
    bit bad;
    clear_all(); build(HDR_W, TRL_W, 1'b0); drive(5, (CH + 3) * 16 + 8, 10, 1'b0, -1); model((CH + 3) * 16 + 8);
    bad = obs_wr.size() != exp_wr.size();
    foreach (exp_wr[i]) if (!bad && obs_wr[i] !== exp_wr[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL short_writes got %0d want %0d (or data differs)", obs_wr.size(), exp_wr.size()); end
    checks++; if (obs_fe !== 1 || obs_fv !== 0) begin failures++; $display("FAIL short_pulses got err=%0d valid=%0d want 1/0", obs_fe, obs_fv); end
    checks++; if (obs_code !== 2'd2) begin failures++; $display("FAIL short_code got %0d want 2", obs_code); end
    checks++; if (busy_seen !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL short_busy got seen=%b now=%b want 1/0", busy_seen, busy); end
  endtask

  task automatic test_trailer_race();
    clear_all(); build(HDR_W, TRL_W, 1'b0); drive(4, FW * 16, 10, 1'b1, -1); model(FW * 16);
    checks++; if (obs_fv !== 1 || obs_fe !== 0) begin failures++; $display("FAIL race_pulses got valid=%0d err=%0d want 1/0", obs_fv, obs_fe); end
    checks++; if (obs_wr.size() != exp_wr.size()) begin failures++; $display("FAIL race_writes got %0d want %0d", obs_wr.size(), exp_wr.size()); end
  endtask

  task automatic test_random_aborts();
    bit bad;
    int n;
    for (int k = 0; k < 4; k++) begin
      clear_all();
      build(($urandom_range(0, 3) == 0) ? 16'($urandom) : HDR_W, TRL_W, 1'b0);
      n = $urandom_range(1, FW * 16 - 1);
      drive($urandom_range(4, 6), n, 10, 1'b0, -1); model(n);
      bad = obs_wr.size() != exp_wr.size();
      foreach (exp_wr[i]) if (!bad && obs_wr[i] !== exp_wr[i]) bad = 1'b1;
      checks++; if (bad) begin failures++; $display("FAIL abort%0d_writes bits=%0d got %0d want %0d (or data differs)", k, n, obs_wr.size(), exp_wr.size()); end
      checks++; if (obs_fe !== exp_fe || obs_fv !== exp_fv) begin failures++; $display("FAIL abort%0d_pulses got err=%0d valid=%0d want %0d/%0d", k, obs_fe, obs_fv, exp_fe, exp_fv); end
      checks++; if (obs_code !== exp_code) begin failures++; $display("FAIL abort%0d_code got %0d want %0d", k, obs_code, exp_code); end
    end
  endtask

  task automatic test_bad_trailer();
    bit bad;
    clear_all(); build(HDR_W, 16'h7A69, 1'b0); drive(5, FW * 16, 10, 1'b0, -1); model(FW * 16);
    bad = obs_wr.size() != exp_wr.size();
    foreach (exp_wr[i]) if (!bad && obs_wr[i] !== exp_wr[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL badtrl_writes got %0d want %0d (or data differs)", obs_wr.size(), exp_wr.size()); end
    checks++; if (obs_fe !== 1 || obs_fv !== 0) begin failures++; $display("FAIL badtrl_pulses got err=%0d valid=%0d want 1/0", obs_fe, obs_fv); end
    checks++; if (err_code !== 2'd3) begin failures++; $display("FAIL badtrl_code got %0d want 3", err_code); end
  endtask

  task automatic test_reset_mid_frame();
    bit bad;
    clear_all(); build(HDR_W, TRL_W, 1'b0); drive(5, FW * 16, 10, 1'b0, 2 * CH * 16 + 5);
    checks++; if (rst_snap !== 24'h0) begin failures++; $display("FAIL midrst_outputs got %h want 000000", rst_snap); end
    checks++; if (obs_wr.size() != 0 || obs_fv != 0 || obs_fe != 0) begin failures++; $display("FAIL midrst_quiet got writes=%0d valid=%0d err=%0d want 0/0/0", obs_wr.size(), obs_fv, obs_fe); end
    clear_all(); build(HDR_W, TRL_W, 1'b0); drive(5, FW * 16, 10, 1'b0, -1); model(FW * 16);
    bad = obs_wr.size() != exp_wr.size();
    foreach (exp_wr[i]) if (!bad && obs_wr[i] !== exp_wr[i]) bad = 1'b1;
    checks++; if (bad || obs_fv !== 1) begin failures++; $display("FAIL midrst_next got writes=%0d valid=%0d want %0d/1", obs_wr.size(), obs_fv, exp_wr.size()); end
  endtask

  task automatic test_back_to_back();
    bit bad;
    clear_all();
    for (int k = 0; k < 4; k++) begin
      build(HDR_W, TRL_W, 1'b0);
      drive((k % 2 == 1) ? 12 : 4, FW * 16, 3, 1'b0, -1);
      model(FW * 16);
    end
    repeat (10) @(negedge Clk200M);
    bad = obs_wr.size() != exp_wr.size();
    foreach (exp_wr[i]) if (!bad && obs_wr[i] !== exp_wr[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL b2b_writes got %0d want %0d (or data differs)", obs_wr.size(), exp_wr.size()); end
    checks++; if (obs_fv !== exp_fv || obs_fe !== 0) begin failures++; $display("FAIL b2b_pulses got valid=%0d err=%0d want %0d/0", obs_fv, obs_fe, exp_fv); end
    checks++; if (multi != 0) begin failures++; $display("FAIL b2b_onehot got %0d multi-strobe cycles want 0", multi); end
  endtask

  initial begin
    clear_all();
    test_reset();
    test_nominal();
    test_bad_header();
    test_short_frame();
    test_trailer_race();
    test_random_aborts();
    test_bad_trailer();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
